// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the two-master memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_timeout
// Description : BUSY-cycle counter with expiry compare for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (busy && !expired) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign expired = busy && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-master / one-slave native memory bus arbiter,
//               one transaction in flight. Optional forced completion on a
//               silent slave when MEM_ARBITER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_valid,
    input  logic                m0_instr,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic                m1_instr,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic                s_instr,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                busy,
    output logic                owner,
    output logic                timeout_flag
);

    state_t r_state;
    owner_t r_owner;
    owner_t r_last_owner;
    owner_t w_grant;
    logic   w_busy;
    logic   w_own_valid;
    logic   w_active;
    logic   w_timeout;
    logic   w_done;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_own_valid = (r_owner == OWNER_M1) ? m1_valid : m0_valid;
    assign w_active    = w_busy && w_own_valid;

    // A tie goes to whichever master did not complete the previous transaction.
    always_comb begin
        w_grant = OWNER_M0;
        if (m0_valid && m1_valid) begin
            w_grant = (r_last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end else if (m1_valid) begin
            w_grant = OWNER_M1;
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic w_start;
    logic w_expired;
    logic r_timeout_flag;

    assign w_start = (r_state == ST_IDLE) && (m0_valid || m1_valid);

    mem_arbiter_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (w_start),
        .busy   (w_busy),
        .expired(w_expired)
    );

    // A real response arriving on the expiry cycle takes precedence.
    assign w_timeout = w_active && w_expired && !s_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timeout_flag <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_flag <= 1'b1;
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    assign w_timeout    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign w_done = w_active && (s_ready || w_timeout);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER_M1;
            r_last_owner <= OWNER_M1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_grant;
                    end
                end
                ST_BUSY: begin
                    // Owner withdrawing early abandons the slot without credit.
                    if (!w_own_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_done) begin
                        r_state      <= ST_IDLE;
                        r_last_owner <= r_owner;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_instr = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (w_busy) begin
            if (r_owner == OWNER_M1) begin
                s_instr = m1_instr;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_instr = m0_instr;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end
    end

    assign s_valid  = w_active && !w_timeout;
    assign m0_ready = w_done && (r_owner == OWNER_M0);
    assign m1_ready = w_done && (r_owner == OWNER_M1);
    assign m0_rdata = w_timeout ? DATA_W'(TIMEOUT_RDATA) : s_rdata;
    assign m1_rdata = w_timeout ? DATA_W'(TIMEOUT_RDATA) : s_rdata;
    assign busy     = w_busy;
    assign owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: vector table, corner
//               sequences and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_valid, m0_instr, m0_ready;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m1_valid, m1_instr, m1_ready;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              s_valid, s_instr, s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_rdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              busy, owner, timeout_flag;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .busy(busy), .owner(owner), .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic v0;
        logic v1;
        logic exp_own;
    } vec_t;

    vec_t vecs[9];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase state: masters, slave responder and reference model.
    logic [ADDR_W-1:0] ra[2];
    logic [DATA_W-1:0] rd[2];
    logic [STRB_W-1:0] rs[2];
    logic              ri[2];
    logic              req[2];
    logic              prev_rdy[2];
    logic              prev_sv, prev_sr;
    bit                pend;
    int                cnt;
    int                cur, gnt, last;
    logic [73:0]       exp_vec;
    logic [73:0]       act_vec;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b1};

        reset_n  = 1'b0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h10;  m0_wdata = '0;           m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'h3;
        s_ready  = 1'b0; s_rdata  = '0;

        // Reset then idle
        tick();
        tick();
        #4;
        check("reset_state",
              {s_valid, s_instr, s_addr, s_wdata, s_wstrb, busy, owner, m0_ready, m1_ready, timeout_flag},
              {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tick();
        reset_n = 1'b1;

        // Vector table: tie/round-robin, single read, write passthrough
        for (int i = 0; i < 9; i++) begin
            m0_valid = vecs[i].v0;
            m1_valid = vecs[i].v1;
            s_ready  = 1'b0;
            #4;
            check($sformatf("v%0d_idle_gap", i), {s_valid, busy, m0_ready, m1_ready}, 4'b0000);
            tick();
            #4;
            check($sformatf("v%0d_grant", i), {s_valid, busy, owner, m0_ready, m1_ready},
                  {1'b1, 1'b1, vecs[i].exp_own, 2'b00});
            check($sformatf("v%0d_req", i), {s_instr, s_addr, s_wdata, s_wstrb},
                  vecs[i].exp_own ? {1'b1, 32'h100, 32'hCAFE_F00D, 4'h3}
                                  : {1'b0, 32'h10, 32'h0, 4'h0});
            tick();
            s_ready = 1'b1;
            s_rdata = 32'h1234_5678 + i;
            #4;
            check($sformatf("v%0d_done", i),
                  {m0_ready, m1_ready, (vecs[i].exp_own ? m1_rdata : m0_rdata)},
                  {~vecs[i].exp_own, vecs[i].exp_own, 32'h1234_5678 + i});
            tick();
            s_ready = 1'b0;
            if (vecs[i].exp_own) m1_valid = 1'b0;
            else                 m0_valid = 1'b0;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        #4;
        check("table_end_idle", {s_valid, busy, owner}, 3'b001);

        // Reset mid-BUSY, late slave response ignored
        tick();
        m0_valid = 1'b1;
        tick();
        #4;
        check("rst_pre", {s_valid, busy, owner}, 3'b110);
        tick();
        reset_n = 1'b0;
        tick();
        m0_valid = 1'b0;
        #4;
        check("rst_mid", {s_valid, busy, owner, m0_ready, m1_ready}, 5'b00100);
        tick();
        reset_n = 1'b1;
        s_ready = 1'b1;
        s_rdata = 32'h5555_AAAA;
        #4;
        check("rst_late_ready", {s_valid, busy, m0_ready, m1_ready}, 4'b0000);
        tick();
        s_ready = 1'b0;

        // Protocol violation by m0 leaves last_owner at m1, so the next tie goes to m0
        m0_valid = 1'b1;
        tick();
        tick();
        m0_valid = 1'b0;
        #4;
        check("viol_drop", {s_valid, busy, m0_ready, m1_ready}, 4'b0100);
        tick();
        #4;
        check("viol_idle", {busy, owner, m0_ready, m1_ready}, 4'b0000);
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        tick();
        #4;
        check("viol_tie_grant", {s_valid, owner}, 2'b10);
        tick();
        s_ready = 1'b1;
        #4;
        check("viol_tie_done", {m0_ready, m1_ready}, 2'b10);
        tick();
        s_ready  = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick();

        // Silent slave
        m0_valid = 1'b1;
        tick();
`ifdef MEM_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            #4;
            check($sformatf("to_wait%0d", k), {m0_ready, m1_ready, timeout_flag, s_valid, busy}, 5'b00011);
            tick();
        end
        #4;
        check("to_fire", {m0_ready, m1_ready, s_valid, m0_rdata}, {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF});
        tick();
        m0_valid = 1'b0;
        #4;
        check("to_flag", {timeout_flag, busy}, 2'b10);
        m1_valid = 1'b1;
        tick();
        tick();
        s_ready = 1'b1;
        tick();
        s_ready  = 1'b0;
        m1_valid = 1'b0;
        #4;
        check("to_sticky", {timeout_flag, busy}, 2'b10);
        tick();
`else
        for (int k = 1; k <= 20; k++) begin
            #4;
            check($sformatf("to_wait%0d", k), {m0_ready, m1_ready, timeout_flag, s_valid, busy}, 5'b00011);
            tick();
        end
        m0_valid = 1'b0;
        tick();
        #4;
        check("to_recover", {busy, timeout_flag, m0_ready}, 3'b000);
        tick();
`endif

        // Randomized run against the behavioural model
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; prev_rdy[m] = 1'b0;
            ra[m] = '0; rd[m] = '0; rs[m] = '0; ri[m] = 1'b0;
        end
        prev_sv = 1'b0; prev_sr = 1'b0; pend = 1'b0; cnt = 0;
        cur = -1; gnt = 1; last = 1;

        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (prev_rdy[m]) begin
                    req[m] = 1'b0;
                end else if (!req[m] && $urandom_range(2) == 0) begin
                    req[m] = 1'b1;
                    ra[m]  = $urandom;
                    rd[m]  = $urandom;
                    rs[m]  = STRB_W'($urandom);
                    ri[m]  = 1'($urandom);
                end else if (req[m] && $urandom_range(40) == 0) begin
                    req[m] = 1'b0;
                end
            end
            s_ready = 1'b0;
            if (prev_sr) begin
                pend = 1'b0;
            end else begin
                if (!pend && prev_sv) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(2);
                end
                if (pend) begin
                    if (cnt == 0) s_ready = 1'b1;
                    else          cnt--;
                end else if ($urandom_range(15) == 0) begin
                    s_ready = 1'b1;
                end
            end
            s_rdata  = $urandom;
            m0_valid = req[0]; m0_addr = ra[0]; m0_wdata = rd[0]; m0_wstrb = rs[0]; m0_instr = ri[0];
            m1_valid = req[1]; m1_addr = ra[1]; m1_wdata = rd[1]; m1_wstrb = rs[1]; m1_instr = ri[1];
            #4;
            if (cur >= 0) begin
                exp_vec = {req[cur], ri[cur], ra[cur], rd[cur], rs[cur],
                           (cur == 0) && req[cur] && s_ready, (cur == 1) && req[cur] && s_ready,
                           1'b1, (gnt == 1)};
            end else begin
                exp_vec = {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, (gnt == 1)};
            end
            act_vec = {s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, busy, owner};
            check($sformatf("rand%0d_bus", c), act_vec, exp_vec);
            if (exp_vec[3]) check($sformatf("rand%0d_rdata0", c), m0_rdata, s_rdata);
            if (exp_vec[2]) check($sformatf("rand%0d_rdata1", c), m1_rdata, s_rdata);
            prev_rdy[0] = m0_ready;
            prev_rdy[1] = m1_ready;
            prev_sv     = s_valid;
            prev_sr     = s_ready;
            if (cur < 0) begin
                if (req[0] || req[1]) begin
                    cur = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
                    gnt = cur;
                end
            end else if (!req[cur]) begin
                cur = -1;
            end else if (s_ready) begin
                last = cur;
                cur  = -1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
